// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and request record for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_READ,
        S_WRITE,
        S_RESP
    } lsu_state_e;

    // Only the fields needed after acceptance are kept; the word address
    // lives in the registered mem_addr.
    typedef struct packed {
        logic [1:0]  size;
        logic        is_unsigned;
        logic [1:0]  off;
        logic [31:0] wdata;
    } lsu_req_t;

    function automatic logic size_err(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            SZ_BAD:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus the word-wide memory port of the LSU.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_out;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_out,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_din, mem_read, mem_write
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_out,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_din, mem_read, mem_write
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [31:0]     rshift;
    logic [31:0]     wshift;
    logic [3:0][7:0] old_b;
    logic [3:0][7:0] new_b;
    logic [3:0][7:0] mrg_b;
    logic [3:0]      lane_en;

    assign rshift = word >> {offset, 3'b000};
    assign wshift = wdata << {offset, 3'b000};

    always_comb begin
        rdata = rshift;
        case (size)
            SZ_BYTE: rdata = {{24{~is_unsigned & rshift[7]}}, rshift[7:0]};
            SZ_HALF: rdata = {{16{~is_unsigned & rshift[15]}}, rshift[15:0]};
            default: rdata = rshift;
        endcase
    end

    assign old_b = word;
    assign new_b = wshift;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        localparam logic [1:0] LN = 2'(i);
        assign lane_en[i] = (size == SZ_WORD) ||
                            (size == SZ_HALF && LN[1] == offset[1]) ||
                            (size == SZ_BYTE && LN == offset);
        assign mrg_b[i] = lane_en[i] ? new_b[i] : old_b[i];
    end

    assign merged = mrg_b;

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store initiator for a word-only memory; sub-word stores use read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 16384
) (
    input logic               clk,
    input logic               reset,
    load_store_unit_if.slave  bus
);

    lsu_state_e  state;
    lsu_req_t    req_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_din_q;
    logic [31:0] align_rdata;
    logic [31:0] align_merged;
    logic        accept;
    logic        acc_err;

    assign accept  = bus.req_valid & req_ready_q;
    assign acc_err = size_err(bus.req_size, bus.req_addr[1:0]) ||
                     ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_DEPTH));

    lsu_align u_align (
        .word        (bus.mem_out),
        .wdata       (req_q.wdata),
        .offset      (req_q.off),
        .size        (req_q.size),
        .is_unsigned (req_q.is_unsigned),
        .rdata       (align_rdata),
        .merged      (align_merged)
    );

    // Every output is a register; pulses default low each cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            req_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        req_q <= '{size:        bus.req_size,
                                   is_unsigned: bus.req_unsigned,
                                   off:         bus.req_addr[1:0],
                                   wdata:       bus.req_wdata};
                        mem_addr_q <= {bus.req_addr[31:2], 2'b00};
                        if (acc_err) begin
                            state        <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (!bus.req_write) begin
                            state      <= S_LOAD;
                            mem_read_q <= 1'b1;
                        end else if (bus.req_size == SZ_WORD) begin
                            state       <= S_WRITE;
                            mem_write_q <= 1'b1;
                            mem_din_q   <= bus.req_wdata;
                        end else begin
                            state      <= S_RMW_READ;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= align_rdata;
                    state        <= S_RESP;
                end
                S_RMW_READ: begin
                    mem_write_q <= 1'b1;
                    mem_din_q   <= align_merged;
                    state       <= S_WRITE;
                end
                S_WRITE: begin
                    resp_valid_q <= 1'b1;
                    state        <= S_RESP;
                end
                S_RESP: begin
                    req_ready_q <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;

endmodule
